polar_result_fifo: RTL

- Downstream stage of the Cartesian-to-cylindrical converter.
- Captures each (r, theta) result pair the converter produces into a small FIFO.
- Presents the pairs to the consumer (output mux / host readout) over a valid/ready handshake.
- Decouples converter throughput from a consumer that stalls; reports occupancy and a sticky overflow flag.

---
 rtl/polar_result_fifo.sv | 96 +++++++++
 1 files changed

// File: rtl/polar_result_fifo.sv
// Result FIFO behind the Cartesian-to-cylindrical converter: buffers (r, theta)
// pairs for a stalling consumer, first-word-fall-through, with sticky overflow.
module polar_result_fifo #(
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     r,
    input  logic [DATA_W-1:0]     theta,
    input  logic                  out_ready,
    input  logic                  clr_ovf,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_r,
    output logic [DATA_W-1:0]     out_theta,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned ENTRY_W = 2 * DATA_W;
    localparam int unsigned PTR_W   = DEPTH_LOG2;
    localparam int unsigned CNT_W   = DEPTH_LOG2 + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push_req;
    logic               pop;
    logic               push;
    logic               drop;
    logic [ENTRY_W-1:0] head;

    // Handshake decode; a full FIFO still accepts a push when it pops the same cycle
    always_comb begin
        push_req = ena & in_valid;
        pop      = ena & out_valid & out_ready;
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    // Status and head presentation, all derived from registered state
    always_comb begin
        out_valid = (count != CNT_W'(0));
        full      = (count == CNT_W'(DEPTH));
        head      = mem[rd_ptr];
        out_r     = '0;
        out_theta = '0;
        if (out_valid) begin
            out_r     = head[ENTRY_W-1:DATA_W];
            out_theta = head[DATA_W-1:0];
        end
    end

    // Storage carries no reset: contents are meaningless while count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {r, theta};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // A drop wins over a same-cycle clear so the loss is never hidden
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
